// File: rtl/program_memory_arbiter_if.sv
// Bus bundle between the program memory arbiter, its two requesters and the
// single-ported program memory.
interface program_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  f_req;
    logic [DATA_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [DATA_WIDTH-1:0] f_rdata;
    logic                  f_err;

    logic                  l_req;
    logic                  l_we;
    logic [DATA_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic                  l_gnt;
    logic                  l_rvalid;
    logic [DATA_WIDTH-1:0] l_rdata;
    logic                  l_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_err,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side.
    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_err,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_memory_arbiter.sv
// Round-robin arbiter sharing single-ported program memory between instruction
// fetch and the loader/debug port; screens bad addresses, 1-cycle responses.
module program_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    program_memory_arbiter_if.slave  bus
);
    typedef enum logic {OWNER_F = 1'b0, OWNER_L = 1'b1} owner_e;

    localparam logic [DATA_WIDTH-3:0] DEPTH_IDX = (DATA_WIDTH-2)'(MEMORY_DEPTH);

    owner_e                last;
    logic                  resp_valid;
    owner_e                resp_owner;
    logic                  resp_err;
    logic                  resp_write;

    logic                  f_win;
    logic                  l_win;
    logic                  accept;
    logic                  legal;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic                  show_f;
    logic                  show_l;
    logic                  resp_data;

    // Fetch loses a conflict only when it was the last one served.
    assign f_win    = bus.f_req && (!bus.l_req || last == OWNER_L);
    assign l_win    = bus.l_req && !f_win;
    assign accept   = !reset && (bus.f_req || bus.l_req);
    assign sel_addr = f_win ? bus.f_addr : bus.l_addr;
    assign req_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[DATA_WIDTH-1:2] >= DEPTH_IDX);
    assign legal    = accept && !req_err;

    // A response registered just before reset is dropped while reset is high.
    assign show_f    = resp_valid && !reset && resp_owner == OWNER_F;
    assign show_l    = resp_valid && !reset && resp_owner == OWNER_L;
    assign resp_data = !resp_err && !resp_write;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus.f_gnt     = 1'b0;
        bus.l_gnt     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (accept) begin
            bus.f_gnt = f_win;
            bus.l_gnt = l_win;
        end
        if (legal) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = l_win && bus.l_we;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = l_win ? bus.l_wdata : '0;
        end

        bus.f_rvalid = show_f;
        bus.f_err    = show_f && resp_err;
        bus.f_rdata  = (show_f && resp_data) ? bus.mem_rdata : '0;
        bus.l_rvalid = show_l;
        bus.l_err    = show_l && resp_err;
        bus.l_rdata  = (show_l && resp_data) ? bus.mem_rdata : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last       <= OWNER_L;
            resp_valid <= 1'b0;
            resp_owner <= OWNER_F;
            resp_err   <= 1'b0;
            resp_write <= 1'b0;
        end else begin
            resp_valid <= accept;
            if (accept) begin
                last       <= f_win ? OWNER_F : OWNER_L;
                resp_owner <= f_win ? OWNER_F : OWNER_L;
                resp_err   <= req_err;
                resp_write <= l_win && bus.l_we;
            end
        end
    end
endmodule
